// File: rtl/ec_point_alu_seq.sv
// Sequential projective point ALU: single-cycle ADD/DOUBLE/PASS and constant-time
// left-to-right double-and-add scalar multiply, with valid/ready on both sides.
module ec_point_alu_seq #(
  parameter int unsigned KW     = 4,
  parameter logic [11:0] INF_PT = 12'h010
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    op,
  input  logic [11:0]   A,
  input  logic [11:0]   B,
  input  logic [KW-1:0] k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [11:0]   R,
  output logic          r_inf,
  output logic          busy
);

  localparam int unsigned CW = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DBL, S_ADDS, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_DBL = 2'b01, OP_SMUL = 2'b10, OP_PASS = 2'b11} op_e;

  state_e          state_q, state_d;
  logic [11:0]     p_q, p_d;
  logic [KW-1:0]   k_q, k_d;
  logic [11:0]     acc_q, acc_d;
  logic            acc_inf_q, acc_inf_d;
  logic [CW-1:0]   i_q, i_d;
  logic [11:0]     r_q, r_d;
  logic            r_inf_q, r_inf_d;
  logic            out_valid_q, out_valid_d;

  logic [11:0]     add_a, add_b, add_s, dbl_in, dbl_s;
  logic            accept, load_r;
  op_e             op_c;

  // The single adder/doubler pair serves direct commands in IDLE and the SMUL loop otherwise.
  assign add_a  = (state_q == S_IDLE) ? A : acc_q;
  assign add_b  = (state_q == S_IDLE) ? B : p_q;
  assign dbl_in = (state_q == S_IDLE) ? A : acc_q;

  pointADD    u_add (.p(add_a), .q(add_b), .s(add_s));
  pointDouble u_dbl (.p(dbl_in), .s(dbl_s));

  assign op_c     = op_e'(op);
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    k_d         = k_q;
    acc_d       = acc_q;
    acc_inf_d   = acc_inf_q;
    i_d         = i_q;
    r_d         = r_q;
    r_inf_d     = r_inf_q;
    load_r      = 1'b0;
    out_valid_d = out_valid_q && !out_ready;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_c)
            OP_ADD: begin
              load_r = 1'b1;
              if (A[11:8] == 4'h0)      r_d = B;
              else if (B[11:8] == 4'h0) r_d = A;
              else                      r_d = add_s;
            end
            OP_DBL: begin
              load_r = 1'b1;
              r_d    = (A[11:8] == 4'h0) ? INF_PT : dbl_s;
            end
            OP_PASS: begin
              load_r = 1'b1;
              r_d    = A;
            end
            default: begin
              p_d       = A;
              k_d       = k;
              acc_d     = INF_PT;
              acc_inf_d = 1'b1;
              i_d       = CW'(KW - 1);
              state_d   = S_DBL;
            end
          endcase
        end
      end
      S_DBL: begin
        if (!acc_inf_q) acc_d = dbl_s;
        state_d = S_ADDS;
      end
      S_ADDS: begin
        if (k_q[i_q]) begin
          if (acc_inf_q) begin
            // An infinite base keeps the accumulator flagged so the result is INF_PT.
            acc_d     = p_q;
            acc_inf_d = (p_q[11:8] == 4'h0);
          end else begin
            acc_d = add_s;
          end
        end
        if (i_q == '0) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q - CW'(1);
          state_d = S_DBL;
        end
      end
      S_DONE: begin
        load_r  = 1'b1;
        r_d     = acc_inf_q ? INF_PT : acc_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load_r) begin
      out_valid_d = 1'b1;
      r_inf_d     = (r_d[11:8] == 4'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      acc_inf_q   <= 1'b0;
      i_q         <= '0;
      r_q         <= '0;
      r_inf_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      acc_inf_q   <= acc_inf_d;
      i_q         <= i_d;
      r_q         <= r_d;
      r_inf_q     <= r_inf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign R         = r_q;
  assign r_inf     = r_inf_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == S_DBL) || (state_q == S_ADDS);

endmodule

// Projective point addition over GF(2^4), reduction polynomial x^4+x+1.
module pointADD (
  input  logic [11:0] p,
  input  logic [11:0] q,
  output logic [11:0] s
);
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r, t;
    r = '0;
    t = a;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  logic [3:0] x3, y3, z3;
  assign x3 = gf_mul(p[3:0], q[11:8]) ^ gf_mul(q[3:0], p[11:8]);
  assign y3 = gf_mul(p[7:4], q[11:8]) ^ gf_mul(q[7:4], p[11:8]) ^ x3;
  assign z3 = gf_mul(p[11:8], q[11:8]);
  assign s  = {z3, y3, x3};
endmodule

// Projective point doubling over GF(2^4), reduction polynomial x^4+x+1.
module pointDouble (
  input  logic [11:0] p,
  output logic [11:0] s
);
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r, t;
    r = '0;
    t = a;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  logic [3:0] x3, y3, z3;
  assign x3 = gf_mul(p[3:0], p[3:0]) ^ gf_mul(p[7:4], p[11:8]);
  assign y3 = gf_mul(p[7:4], p[7:4]) ^ x3;
  assign z3 = gf_mul(p[11:8], p[11:8]);
  assign s  = {z3, y3, x3};
endmodule

// File: tb/tb_ec_point_alu_seq.sv
// Randomized self-checking bench for ec_point_alu_seq against a plain-arithmetic point model.
module tb_ec_point_alu_seq;
  localparam int unsigned KW = 4;
  localparam logic [11:0] INF = 12'h010;
  localparam logic [1:0] OPADD = 2'b00, OPDBL = 2'b01, OPSMUL = 2'b10, OPPASS = 2'b11;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, r_inf, busy;
  logic [1:0]    op;
  logic [11:0]   A, B, R;
  logic [KW-1:0] k;

  int checks = 0;
  int errors = 0;

  ec_point_alu_seq #(.KW(KW), .INF_PT(INF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .A(A), .B(B), .k(k), .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .r_inf(r_inf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(16) product: carry-less multiply, then reduce the high bits by x^4+x+1 (0x13).
  function automatic logic [3:0] m_mul(input logic [3:0] a, input logic [3:0] b);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (int'(a) << i);
    for (int bt = 6; bt >= 4; bt--) if (((p >> bt) & 1) == 1) p = p ^ (19 << (bt - 4));
    return 4'(p);
  endfunction

  function automatic logic [11:0] m_add(input logic [11:0] a, input logic [11:0] b);
    logic [3:0] x1, y1, z1, x2, y2, z2, x3;
    x1 = a[3:0]; y1 = a[7:4]; z1 = a[11:8];
    x2 = b[3:0]; y2 = b[7:4]; z2 = b[11:8];
    if (z1 == 0) return b;
    if (z2 == 0) return a;
    x3 = m_mul(x1, z2) ^ m_mul(x2, z1);
    return {m_mul(z1, z2), m_mul(y1, z2) ^ m_mul(y2, z1) ^ x3, x3};
  endfunction

  function automatic logic [11:0] m_dbl(input logic [11:0] a);
    logic [3:0] x, y, z, x3;
    x = a[3:0]; y = a[7:4]; z = a[11:8];
    if (z == 0) return INF;
    x3 = m_mul(x, x) ^ m_mul(y, z);
    return {m_mul(z, z), m_mul(y, y) ^ x3, x3};
  endfunction

  function automatic logic [11:0] m_smul(input logic [11:0] p, input logic [KW-1:0] kk);
    logic [11:0] acc;
    acc = INF;
    for (int i = KW - 1; i >= 0; i--) begin
      acc = m_dbl(acc);
      if (kk[i]) acc = m_add(acc, p);
    end
    if (acc[11:8] == 0) acc = INF;
    return acc;
  endfunction

  function automatic logic [11:0] m_op(input logic [1:0] o, input logic [11:0] a,
                                       input logic [11:0] b, input logic [KW-1:0] kk);
    case (o)
      OPADD:   return m_add(a, b);
      OPDBL:   return m_dbl(a);
      OPSMUL:  return m_smul(a, kk);
      default: return a;
    endcase
  endfunction

  // Issue one command, then count edges after the accepting edge until out_valid appears.
  task automatic issue(input logic [1:0] o, input logic [11:0] a, input logic [11:0] b,
                       input logic [KW-1:0] kk, output logic [11:0] r, output logic ri,
                       output int lat, output int bcnt);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    op = o; A = a; B = b; k = kk; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (busy) bcnt++;
    end
    r  = R;
    ri = r_inf;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; A = '0; B = '0; k = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, R, r_inf, busy, in_ready} !== {1'b0, 12'h000, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got ov=%b R=%h rinf=%b busy=%b rdy=%b, want ov=0 R=000 rinf=0 busy=0 rdy=1",
               out_valid, R, r_inf, busy, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_pass_add_inf();
    logic [11:0] r; logic ri; int lat, bc;
    issue(OPPASS, 12'h321, 12'h000, '0, r, ri, lat, bc);
    checks++;
    if ({r, ri, lat} !== {12'h321, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL pass: got R=%h rinf=%b lat=%0d, want R=321 rinf=0 lat=0", r, ri, lat);
    end
    issue(OPADD, 12'h0A5, 12'h123, '0, r, ri, lat, bc);
    checks++;
    if (r !== 12'h123 || ri !== 1'b0) begin
      errors++; $display("FAIL add_a_inf: got R=%h rinf=%b, want R=123 rinf=0", r, ri);
    end
    issue(OPADD, 12'h123, 12'h0A5, '0, r, ri, lat, bc);
    checks++;
    if (r !== 12'h123 || ri !== 1'b0) begin
      errors++; $display("FAIL add_b_inf: got R=%h rinf=%b, want R=123 rinf=0", r, ri);
    end
    issue(OPDBL, 12'h0A5, 12'h000, '0, r, ri, lat, bc);
    checks++;
    if (r !== INF || ri !== 1'b1) begin
      errors++; $display("FAIL dbl_inf: got R=%h rinf=%b, want R=%h rinf=1", r, ri, INF);
    end
  endtask

  task automatic test_smul_fixed();
    logic [11:0] r, exp_r; logic ri; int lat, bc;
    logic [KW-1:0] ks [4];
    logic [11:0]   es [4];
    logic [11:0]   a0;
    a0 = 12'h1C3;
    ks[0] = 4'd0;     es[0] = INF;
    ks[1] = 4'd1;     es[1] = a0;
    ks[2] = 4'd2;     es[2] = m_dbl(a0);
    ks[3] = 4'b1011;  es[3] = m_add(m_dbl(m_add(m_dbl(m_dbl(a0)), a0)), a0);
    for (int i = 0; i < 4; i++) begin
      issue(OPSMUL, a0, 12'h000, ks[i], r, ri, lat, bc);
      exp_r = es[i];
      checks++;
      if (r !== exp_r || ri !== (exp_r[11:8] == 0)) begin
        errors++; $display("FAIL smul_k%0h: got R=%h rinf=%b, want R=%h", ks[i], r, ri, exp_r);
      end
      checks++;
      if (lat !== 2 * KW + 1 || bc !== 2 * KW) begin
        errors++;
        $display("FAIL smul_timing_k%0h: got lat=%0d busy=%0d, want lat=%0d busy=%0d",
                 ks[i], lat, bc, 2 * KW + 1, 2 * KW);
      end
    end
    issue(OPSMUL, 12'h0A5, 12'h000, 4'b1111, r, ri, lat, bc);
    checks++;
    if (r !== INF || ri !== 1'b1 || lat !== 2 * KW + 1) begin
      errors++; $display("FAIL smul_p_inf: got R=%h rinf=%b lat=%0d, want R=%h rinf=1 lat=%0d",
                         r, ri, lat, INF, 2 * KW + 1);
    end
  endtask

  task automatic test_random();
    logic [11:0] r, a, b, e; logic ri; int lat, bc; logic [1:0] o; logic [KW-1:0] kk;
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(3)); a = 12'($urandom); b = 12'($urandom); kk = KW'($urandom);
      if ($urandom_range(3) == 0) a[11:8] = 4'h0;
      if ($urandom_range(3) == 0) b[11:8] = 4'h0;
      e = m_op(o, a, b, kk);
      issue(o, a, b, kk, r, ri, lat, bc);
      checks++;
      if (r !== e || ri !== (e[11:8] == 0) || lat !== ((o == OPSMUL) ? 2 * KW + 1 : 0)) begin
        errors++;
        $display("FAIL random op=%0d A=%h B=%h k=%h: got R=%h rinf=%b lat=%0d, want R=%h",
                 o, a, b, kk, r, ri, lat, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] a, b, e; logic [1:0] o; int rdy_bad;
    rdy_bad = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      o = 2'($urandom_range(2));
      if (o == OPSMUL) o = OPPASS;
      a = 12'($urandom); b = 12'($urandom);
      op = o; A = a; B = b; k = '0; in_valid = 1'b1;
      e = m_op(o, a, b, '0);
      if (!in_ready) rdy_bad++;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || R !== e) begin
        errors++; $display("FAIL b2b_%0d: got ov=%b R=%h, want ov=1 R=%h", n, out_valid, R, e);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (rdy_bad !== 0) begin
      errors++; $display("FAIL b2b_ready: got %0d stalled cycles, want 0", rdy_bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int guard;
    out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    op = OPPASS; A = 12'h456; B = '0; k = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    op = OPDBL; A = 12'h9AB;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || R !== 12'h456 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: got ov=%b R=%h rdy=%b, want ov=1 R=456 rdy=0", c, out_valid, R, in_ready);
      end
      @(posedge clk); #1;
    end
    op = OPPASS; A = 12'h789; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL drain_ready: got rdy=%b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || R !== 12'h789) begin
      errors++; $display("FAIL drain_accept: got ov=%b R=%h, want ov=1 R=789", out_valid, R);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int seen;
    out_ready = 1'b1;
    op = OPSMUL; A = 12'h1C3; B = '0; k = 4'b1101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({out_valid, R, r_inf, busy} !== {1'b0, 12'h000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_reset: got ov=%b R=%h rinf=%b busy=%b, want ov=0 R=000 rinf=0 busy=0",
               out_valid, R, r_inf, busy);
    end
    seen = 0;
    for (int c = 0; c < 2 * KW + 6; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_silent: got %0d active cycles, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_pass_add_inf();
    test_smul_fixed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
